jk_bank_sequencer: RTL and testbench



---
 rtl/jk_bank_sequencer_if.sv | 21 ++
 rtl/jk_bank_sequencer.sv | 127 ++++++++++++
 tb/tb_jk_bank_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Command channel for jk_bank_sequencer: valid/ready handshake carrying op, data and step count.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_steps;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// JK bank sequencer: single ops update q one edge after accept, counts take S edges; done pulses after.
// Ready only in IDLE (never queues). Define JK_SEQ_DOWN_EN to build DOWN counting (else op 6 acts as NOP).
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    jk_bank_sequencer_if.slave cmd,
    output logic [WIDTH-1:0]   j_out,
    output logic [WIDTH-1:0]   k_out,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;

    logic [1:0]       state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] steps_r;
    logic             is_apply_op;
    logic             is_count_op;

    // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
    function automatic logic [WIDTH-1:0] carry_mask(input logic [WIDTH-1:0] bits);
        logic [WIDTH-1:0] m;
        m[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            m[i] = m[i-1] & bits[i-1];
        end
        return m;
    endfunction

    always_comb begin
        is_apply_op = (cmd.cmd_op >= OP_CLEAR) && (cmd.cmd_op <= OP_TOGGLE);
`ifdef JK_SEQ_DOWN_EN
        is_count_op = (cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DOWN);
`else
        is_count_op = (cmd.cmd_op == OP_UP);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_r    <= '0;
            data_r  <= '0;
            steps_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r    <= cmd.cmd_op;
                        data_r  <= cmd.cmd_data;
                        steps_r <= cmd.cmd_steps;
                        if (is_apply_op)
                            state <= S_APPLY;
                        else if (is_count_op && (cmd.cmd_steps != '0))
                            state <= S_COUNT;
                        else
                            state <= S_DONE;
                    end
                end
                S_APPLY: state <= S_DONE;
                S_COUNT: begin
                    steps_r <= steps_r - CNT_W'(1);
                    if (steps_r <= CNT_W'(1))
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        j_out = '0;
        k_out = '0;
        if (state == S_APPLY) begin
            case (op_r)
                OP_CLEAR:  k_out = '1;
                OP_SET:    j_out = '1;
                OP_LOAD: begin
                    j_out = data_r;
                    k_out = ~data_r;
                end
                OP_TOGGLE: begin
                    j_out = data_r;
                    k_out = data_r;
                end
                default: ;
            endcase
        end else if (state == S_COUNT) begin
            if (op_r == OP_UP) begin
                j_out = carry_mask(q);
                k_out = carry_mask(q);
            end
`ifdef JK_SEQ_DOWN_EN
            else if (op_r == OP_DOWN) begin
                j_out = carry_mask(~q);
                k_out = carry_mask(~q);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= (j_out & ~q) | (~k_out & q);
    end

    assign cmd.cmd_ready = (state == S_IDLE) && !rst;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Randomized and directed bench for jk_bank_sequencer against a arithmetic bank model.
module tb_jk_bank_sequencer;
    localparam int W = 4;
    localparam int C = 8;
`ifdef JK_SEQ_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_bank_sequencer_if #(.WIDTH(W), .CNT_W(C)) cmd ();
    logic [W-1:0] j_out, k_out, q;
    logic         busy, done;

    jk_bank_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .cmd(cmd),
        .j_out(j_out), .k_out(k_out), .q(q), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] mq;

    // Presents a command at a falling edge, waits for the accepting rising edge, then scrambles the bus.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] data, input logic [C-1:0] steps);
        @(negedge clk);
        cmd.cmd_valid = 1'b1; cmd.cmd_op = op; cmd.cmd_data = data; cmd.cmd_steps = steps;
        for (int t = 0; t < 40 && cmd.cmd_ready !== 1'b1; t++) @(negedge clk);
        n_cmp++; if (cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd.cmd_ready); end
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 3'($urandom_range(0, 7));
        cmd.cmd_data  = W'($urandom_range(0, 15));
        cmd.cmd_steps = C'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && busy !== 1'b0; t++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_timeout: busy=%b want 0", busy); end
    endtask

    task automatic test_reset();
        cmd.cmd_valid = 1'b0; cmd.cmd_op = 3'd0; cmd.cmd_data = '0; cmd.cmd_steps = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmd.cmd_valid = 1'b1; cmd.cmd_op = 3'd2;
        @(negedge clk);
        n_cmp++; if (cmd.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", cmd.cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL rst_q: got %b want 0000", q); end
        rst = 1'b0; cmd.cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", cmd.cmd_ready); end
        n_cmp++; if ({j_out, k_out} !== 8'h00) begin n_err++; $display("FAIL rst_jk: got %b/%b want 0000/0000", j_out, k_out); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rst_busy_done: got %b want 00", {busy, done}); end
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL post_rst_q: got %b want 0000", q); end
        mq = '0;
    endtask

    task automatic test_load();
        issue(3'd3, 4'b1010, '0);
        @(negedge clk);
        n_cmp++; if (j_out !== 4'b1010 || k_out !== 4'b0101) begin n_err++; $display("FAIL load_jk: got %b/%b want 1010/0101", j_out, k_out); end
        n_cmp++; if (q !== mq || done !== 1'b0) begin n_err++; $display("FAIL load_early: q=%b done=%b want %b/0", q, done, mq); end
        @(negedge clk);
        n_cmp++; if (q !== 4'b1010 || done !== 1'b1) begin n_err++; $display("FAIL load_q_done: q=%b done=%b want 1010/1", q, done); end
        n_cmp++; if ({j_out, k_out} !== 8'h00) begin n_err++; $display("FAIL load_jk_hold: got %b/%b want 0000/0000", j_out, k_out); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL load_end: done=%b ready=%b want 0/1", done, cmd.cmd_ready); end
        mq = 4'b1010;
    endtask

    task automatic test_up_wrap();
        int busy_cnt = 0, done_cnt = 0;
        issue(3'd3, 4'b1110, '0); wait_idle();
        issue(3'd5, '0, 8'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            busy_cnt += int'(busy); done_cnt += int'(done);
            if (k < 4) begin
                n_cmp++; if (q !== 4'(4'b1110 + k)) begin n_err++; $display("FAIL up_q[%0d]: got %b want %b", k, q, 4'(4'b1110 + k)); end
                n_cmp++; if (done !== (k == 3)) begin n_err++; $display("FAIL up_done[%0d]: got %b want %b", k, done, k == 3); end
            end
        end
        n_cmp++; if (busy_cnt != 4) begin n_err++; $display("FAIL up_busy_cycles: got %0d want 4", busy_cnt); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL up_done_pulses: got %0d want 1", done_cnt); end
        mq = 4'b0001;
    endtask

    task automatic test_down();
        issue(3'd3, 4'b0001, '0); wait_idle();
        issue(3'd6, '0, 8'd2);
`ifdef JK_SEQ_DOWN_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin
                n_cmp++; if (q !== 4'(4'b0001 - k)) begin n_err++; $display("FAIL down_q[%0d]: got %b want %b", k, q, 4'(4'b0001 - k)); end
            end
            n_cmp++; if (done !== (k == 2)) begin n_err++; $display("FAIL down_done[%0d]: got %b want %b", k, done, k == 2); end
        end
        mq = 4'b1111;
`else
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || q !== 4'b0001) begin n_err++; $display("FAIL down_nop: done=%b q=%b want 1/0001", done, q); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || q !== 4'b0001 || cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL down_nop_end: done=%b q=%b ready=%b want 0/0001/1", done, q, cmd.cmd_ready); end
        mq = 4'b0001;
`endif
    endtask

    task automatic test_toggle_clear_set();
        logic [2:0]   ops [3] = '{3'd4, 3'd1, 3'd2};
        logic [W-1:0] dat [3] = '{4'b0011, 4'b0000, 4'b0000};
        logic [W-1:0] ej  [3] = '{4'b0011, 4'b0000, 4'b1111};
        logic [W-1:0] ek  [3] = '{4'b0011, 4'b1111, 4'b0000};
        logic [W-1:0] eq  [3] = '{4'b0101, 4'b0000, 4'b1111};
        issue(3'd3, 4'b0110, '0); wait_idle();
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], dat[i], '0);
            @(negedge clk);
            n_cmp++; if (j_out !== ej[i] || k_out !== ek[i]) begin n_err++; $display("FAIL tcs_jk[%0d]: got %b/%b want %b/%b", i, j_out, k_out, ej[i], ek[i]); end
            @(negedge clk);
            n_cmp++; if (q !== eq[i]) begin n_err++; $display("FAIL tcs_q[%0d]: got %b want %b", i, q, eq[i]); end
            wait_idle();
        end
        mq = 4'b1111;
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] start = mq;
        issue(3'd5, '0, 8'd200);
        repeat (50) @(negedge clk);
        n_cmp++; if (q !== 4'(start + 49)) begin n_err++; $display("FAIL mid_q: got %b want %b", q, 4'(start + 49)); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_rst: q=%b busy=%b done=%b want 0000/0/0", q, busy, done); end
        n_cmp++; if (cmd.cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", cmd.cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd.cmd_ready !== 1'b1 || done !== 1'b0 || q !== 4'b0000) begin n_err++; $display("FAIL mid_after: ready=%b done=%b q=%b want 1/0/0000", cmd.cmd_ready, done, q); end
        mq = '0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] start = mq;
        @(negedge clk);
        cmd.cmd_valid = 1'b1; cmd.cmd_op = 3'd5; cmd.cmd_data = 4'b0110; cmd.cmd_steps = 8'd4;
        n_cmp++; if (cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", cmd.cmd_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (cmd.cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 0", k, cmd.cmd_ready); end
            n_cmp++; if (q !== 4'(start + k)) begin n_err++; $display("FAIL b2b_q[%0d]: got %b want %b", k, q, 4'(start + k)); end
            cmd.cmd_op = (k == 4) ? 3'd3 : ((k % 2 == 0) ? 3'd1 : 3'd2);
            cmd.cmd_data = 4'b1001;
        end
        @(negedge clk);
        n_cmp++; if (cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b want 1", cmd.cmd_ready); end
        @(posedge clk); #1 cmd.cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (j_out !== 4'b1001 || k_out !== 4'b0110) begin n_err++; $display("FAIL b2b_second_jk: got %b/%b want 1001/0110", j_out, k_out); end
        @(negedge clk);
        n_cmp++; if (q !== 4'b1001) begin n_err++; $display("FAIL b2b_second_q: got %b want 1001", q); end
        wait_idle();
        mq = 4'b1001;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [2:0]   op    = 3'($urandom_range(0, 7));
            logic [W-1:0] data  = W'($urandom_range(0, 15));
            logic [C-1:0] steps = C'($urandom_range(0, 5));
            bit           apply = (op >= 3'd1) && (op <= 3'd4);
            int           cnt   = (op == 3'd5 || (op == 3'd6 && DOWN_EN)) ? int'(steps) : 0;
            logic [W-1:0] ej, ek, nq, cur, nxt;
            issue(op, data, steps);
            if (apply) begin
                case (op)
                    3'd1:    begin ej = '0;   ek = '1;    nq = '0; end
                    3'd2:    begin ej = '1;   ek = '0;    nq = '1; end
                    3'd3:    begin ej = data; ek = ~data; nq = data; end
                    default: begin ej = data; ek = data;  nq = mq ^ data; end
                endcase
                @(negedge clk);
                n_cmp++; if (j_out !== ej || k_out !== ek || q !== mq || done !== 1'b0) begin n_err++; $display("FAIL rnd_apply[%0d] op%0d: j/k/q/done=%b/%b/%b/%b want %b/%b/%b/0", it, op, j_out, k_out, q, done, ej, ek, mq); end
                @(negedge clk);
                n_cmp++; if (q !== nq || done !== 1'b1) begin n_err++; $display("FAIL rnd_result[%0d] op%0d: q/done=%b/%b want %b/1", it, op, q, done, nq); end
            end else if (cnt > 0) begin
                cur = mq;
                for (int k = 0; k < cnt; k++) begin
                    nxt = (op == 3'd5) ? cur + W'(1) : cur - W'(1);
                    @(negedge clk);
                    n_cmp++; if (q !== cur || j_out !== (cur ^ nxt) || k_out !== (cur ^ nxt) || done !== 1'b0) begin n_err++; $display("FAIL rnd_count[%0d.%0d] op%0d: q/j/k/done=%b/%b/%b/%b want %b/%b/%b/0", it, k, op, q, j_out, k_out, done, cur, cur ^ nxt, cur ^ nxt); end
                    cur = nxt;
                end
                nq = cur;
                @(negedge clk);
                n_cmp++; if (q !== nq || done !== 1'b1) begin n_err++; $display("FAIL rnd_count_end[%0d] op%0d: q/done=%b/%b want %b/1", it, op, q, done, nq); end
            end else begin
                nq = mq;
                @(negedge clk);
                n_cmp++; if (done !== 1'b1 || q !== mq || {j_out, k_out} !== 8'h00) begin n_err++; $display("FAIL rnd_nop[%0d] op%0d: done/q/j/k=%b/%b/%b/%b want 1/%b/0000/0000", it, op, done, q, j_out, k_out, mq); end
            end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || cmd.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rnd_tail[%0d]: done/ready=%b/%b want 0/1", it, done, cmd.cmd_ready); end
            mq = nq;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up_wrap();
        test_down();
        test_toggle_clear_set();
        test_reset_mid_count();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
